// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: funct codes, ALU select codes,
// FSM state encoding and the decoder result bundle.
package alu_issue_ctrl_pkg;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  localparam logic [2:0] SEL_ADD  = 3'b000;
  localparam logic [2:0] SEL_SUB  = 3'b001;
  localparam logic [2:0] SEL_AND  = 3'b010;
  localparam logic [2:0] SEL_OR   = 3'b011;
  localparam logic [2:0] SEL_SLT  = 3'b100;
  localparam logic [2:0] SEL_MUL  = 3'b110;
  localparam logic [2:0] SEL_IDLE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0] sel;
    logic       legal;
    logic       is_mul;
    logic       is_nop;
  } dec_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the instruction, register-file, ALU and writeback signals around the issue controller.
// master = controller side, slave = surrounding pipeline/testbench side.
interface alu_issue_ctrl_if #(parameter int CNT_W = 16);

  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic [4:0]       rs_addr;
  logic [4:0]       rt_addr;
  logic [31:0]      rs_data;
  logic [31:0]      rt_data;
  logic [31:0]      op1;
  logic [31:0]      op2;
  logic [2:0]       sel;
  logic [31:0]      alu_result;
  logic             alu_zero;
  logic             wb_valid;
  logic             wb_ready;
  logic [4:0]       wb_addr;
  logic [31:0]      wb_data;
  logic             wb_zero;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  instr_valid, instr, rs_data, rt_data, alu_result, alu_zero, wb_ready,
    output instr_ready, rs_addr, rt_addr, op1, op2, sel,
           wb_valid, wb_addr, wb_data, wb_zero, illegal, retired
  );

  modport slave (
    output instr_valid, instr, rs_data, rt_data, alu_result, alu_zero, wb_ready,
    input  instr_ready, rs_addr, rt_addr, op1, op2, sel,
           wb_valid, wb_addr, wb_data, wb_zero, illegal, retired
  );

endinterface

// File: rtl/alu_issue_ctrl_funct_decode.sv
// Combinational R-type decoder: instruction word -> ALU select, legal, is_mul, is_nop.
// Zero cycles latency; no flow control.
module alu_funct_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  always_comb begin
    dec     = '0;
    dec.sel = SEL_IDLE;
    if (instr == 32'd0) begin
      dec.legal  = 1'b1;
      dec.is_nop = 1'b1;
    end else if (instr[31:26] == 6'd0) begin
      dec.legal = 1'b1;
      case (instr[5:0])
        FN_ADD:  dec.sel = SEL_ADD;
        FN_SUB:  dec.sel = SEL_SUB;
        FN_AND:  dec.sel = SEL_AND;
        FN_OR:   dec.sel = SEL_OR;
        FN_SLT:  dec.sel = SEL_SLT;
        FN_MUL: begin
          dec.sel    = SEL_MUL;
          dec.is_mul = 1'b1;
        end
        default: dec.legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU front-end: accepts one R-type instruction at a time, reads operands, holds the ALU, emits a wb beat.
// Accept-to-wb_valid is 2+N cycles (N = MUL_LATENCY for MUL, else 1); wb beat held until wb_ready.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_ctrl_if.master  bus
);

  localparam int LAT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  state_t           state, state_nxt;
  dec_t             dec;
  logic             accept, exec_last, retire;
  logic [4:0]       rs_q, rt_q, rd_q;
  logic [2:0]       sel_pend, sel_q;
  logic             mul_pend;
  logic [LAT_W-1:0] lat_cnt;
  logic [31:0]      op1_q, op2_q, result_q;
  logic             zero_q, illegal_q;
  logic [CNT_W-1:0] retired_q;

  alu_funct_decode u_decode (
    .instr (bus.instr),
    .dec   (dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    accept          = 1'b0;
    exec_last       = 1'b0;
    retire          = 1'b0;
    bus.instr_ready = 1'b0;
    bus.wb_valid    = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.instr_ready = rst_n;
        accept          = bus.instr_valid;
        retire          = accept && dec.is_nop;
        if (accept && dec.legal && !dec.is_nop) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        exec_last = (lat_cnt == '0);
        if (exec_last) begin
          // rd==0 results are discarded but the instruction still counts as retired
          if (rd_q == 5'd0) begin
            retire    = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_WB;
          end
        end
      end
      ST_WB: begin
        bus.wb_valid = 1'b1;
        if (bus.wb_ready) begin
          retire    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      sel_pend  <= SEL_IDLE;
      mul_pend  <= 1'b0;
      sel_q     <= SEL_IDLE;
      lat_cnt   <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      illegal_q <= accept && !dec.legal;
      if (accept) begin
        rs_q     <= bus.instr[25:21];
        rt_q     <= bus.instr[20:16];
        rd_q     <= bus.instr[15:11];
        sel_pend <= dec.sel;
        mul_pend <= dec.is_mul;
      end
      if (state == ST_ISSUE) begin
        op1_q   <= bus.rs_data;
        op2_q   <= bus.rt_data;
        sel_q   <= sel_pend;
        lat_cnt <= mul_pend ? LAT_W'(MUL_LATENCY - 1) : '0;
      end
      if (state == ST_EXEC) begin
        if (exec_last) begin
          result_q <= bus.alu_result;
          zero_q   <= bus.alu_zero;
        end else begin
          lat_cnt <= lat_cnt - 1'b1;
        end
      end
      if (state != ST_IDLE && state_nxt == ST_IDLE) sel_q <= SEL_IDLE;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  assign bus.rs_addr = rs_q;
  assign bus.rt_addr = rt_q;
  assign bus.op1     = op1_q;
  assign bus.op2     = op2_q;
  assign bus.sel     = sel_q;
  assign bus.wb_addr = rd_q;
  assign bus.wb_data = result_q;
  assign bus.wb_zero = zero_q;
  assign bus.illegal = illegal_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: register file and ALU models around the DUT, a reference model
// that predicts each writeback beat, and a monitor that checks beats against the expected queue.
module tb_alu_issue_ctrl;

  localparam int MUL_LAT = 3;
  localparam int CNT_W   = 16;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        zero;
    int          first_cyc;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      regs [32];
  beat_t            exp_q [$];
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  bit               stall = 1'b0;
  bit               in_beat = 1'b0;
  logic [CNT_W-1:0] model_retired = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_ctrl_if #(.CNT_W(CNT_W)) bus ();

  alu_issue_ctrl #(.MUL_LATENCY(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always_comb begin
    bus.rs_data = regs[bus.rs_addr];
    bus.rt_data = regs[bus.rt_addr];
  end

  always_comb begin
    bus.alu_result = '0;
    case (bus.sel)
      3'b000:  bus.alu_result = bus.op1 + bus.op2;
      3'b001:  bus.alu_result = bus.op1 - bus.op2;
      3'b010:  bus.alu_result = bus.op1 & bus.op2;
      3'b011:  bus.alu_result = bus.op1 | bus.op2;
      3'b100:  bus.alu_result = {31'd0, $signed(bus.op1) < $signed(bus.op2)};
      3'b110:  bus.alu_result = bus.op1 * bus.op2;
      default: bus.alu_result = '0;
    endcase
    bus.alu_zero = (bus.alu_result == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] rand_instr();
    int k;
    logic [5:0] f;
    logic [31:0] w;
    k = $urandom_range(0, 9);
    w = {6'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'd0};
    case (k)
      0: w[5:0] = 6'h20;
      1: w[5:0] = 6'h22;
      2: w[5:0] = 6'h24;
      3: w[5:0] = 6'h25;
      4: w[5:0] = 6'h2a;
      5: w[5:0] = 6'h18;
      6: w = 32'd0;
      7: begin
        w[31:26] = 6'($urandom_range(1, 63));
        w[5:0]   = 6'h20;
      end
      8: begin
        do f = 6'($urandom);
        while (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2a || f == 6'h18);
        w[5:0] = f;
      end
      default: begin
        w[15:11] = 5'd0;
        w[5:0]   = 6'h22;
      end
    endcase
    return w;
  endfunction

  task automatic randomize_regs();
    for (int i = 0; i < 32; i++)
      regs[i] = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
  endtask

  // Reference model: predicts legality, select, result and timing from the instruction word alone.
  task automatic send(input logic [31:0] ins);
    logic [31:0] a, b, res;
    logic [2:0]  sel;
    logic [4:0]  rd;
    bit          nop, legal, mul;
    int          n, a_cyc, waited;
    a = regs[ins[25:21]];
    b = regs[ins[20:16]];
    rd = ins[15:11];
    nop = (ins == 32'd0);
    legal = nop;
    mul = 1'b0;
    sel = 3'b111;
    res = '0;
    if (!nop && ins[31:26] == 6'd0) begin
      case (ins[5:0])
        6'h20: begin legal = 1; sel = 3'b000; res = a + b; end
        6'h22: begin legal = 1; sel = 3'b001; res = a - b; end
        6'h24: begin legal = 1; sel = 3'b010; res = a & b; end
        6'h25: begin legal = 1; sel = 3'b011; res = a | b; end
        6'h2a: begin legal = 1; sel = 3'b100; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        6'h18: begin legal = 1; sel = 3'b110; res = a * b; mul = 1; end
        default: ;
      endcase
    end
    n = mul ? MUL_LAT : 1;

    @(negedge clk);
    waited = 0;
    while (!bus.instr_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.instr_ready) begin
      chk("accept_timeout", 32'(bus.instr_ready), 32'd1);
      return;
    end
    bus.instr_valid = 1'b1;
    bus.instr = ins;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    a_cyc = cyc;
    chk("illegal_pulse", 32'(bus.illegal), legal ? 32'd0 : 32'd1);

    if (!legal) begin
      chk("ready_after_illegal", 32'(bus.instr_ready), 32'd1);
      @(negedge clk);
      chk("illegal_one_cycle", 32'(bus.illegal), 32'd0);
    end else if (nop) begin
      model_retired++;
      chk("ready_after_nop", 32'(bus.instr_ready), 32'd1);
    end else begin
      if (rd != 5'd0) exp_q.push_back('{rd, res, (res == 32'd0), a_cyc + 1 + n});
      chk("issue_rs_addr", 32'(bus.rs_addr), 32'(ins[25:21]));
      chk("issue_rt_addr", 32'(bus.rt_addr), 32'(ins[20:16]));
      chk("ready_in_issue", 32'(bus.instr_ready), 32'd0);
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        chk("exec_op1", bus.op1, a);
        chk("exec_op2", bus.op2, b);
        chk("exec_sel", 32'(bus.sel), 32'(sel));
      end
      waited = 0;
      while (!bus.instr_ready && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      chk("complete", 32'(bus.instr_ready), 32'd1);
      chk("idle_sel", 32'(bus.sel), 32'd7);
      model_retired++;
    end
    chk("retired", 32'(bus.retired), 32'(model_retired));
  endtask

  initial begin
    bus.wb_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.wb_ready = stall ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: every cycle a beat is presented it must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.wb_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected: beat addr=%0d data=0x%0h with nothing expected", bus.wb_addr, bus.wb_data);
        end else begin
          if (!in_beat) chk("wb_latency", 32'(cyc), 32'(exp_q[0].first_cyc));
          chk("wb_addr", 32'(bus.wb_addr), 32'(exp_q[0].addr));
          chk("wb_data", bus.wb_data, exp_q[0].data);
          chk("wb_zero", 32'(bus.wb_zero), 32'(exp_q[0].zero));
          chk("ready_in_wb", 32'(bus.instr_ready), 32'd0);
          in_beat = 1'b1;
          if (bus.wb_ready) begin
            void'(exp_q.pop_front());
            in_beat = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    randomize_regs();
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.instr_ready), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd7);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_retired", 32'(bus.retired), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_op1", bus.op1, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.instr_ready), 32'd1);

    regs[5] = 32'd3; regs[10] = 32'd7;
    send(32'h00AAD02A);
    regs[1] = 32'd5; regs[2] = 32'd9;
    send(32'h0022A020);
    regs[7] = 32'd42;
    send(mk_r(7, 7, 12, 6'h22));
    regs[3] = 32'd6; regs[4] = 32'd7;
    send(mk_r(3, 4, 9, 6'h18));
    send(32'h0000003F);
    send(32'h00000000);

    // Backpressure: hold the sink off for four cycles of a presented beat.
    stall = 1'b1;
    regs[1] = 32'd100; regs[2] = 32'd23;
    fork
      send(mk_r(1, 2, 17, 6'h25));
      begin
        waited = 0;
        while (!bus.wb_valid && waited < 20) begin
          @(negedge clk);
          waited++;
        end
        chk("bp_wb_valid_seen", 32'(bus.wb_valid), 32'd1);
        repeat (4) begin
          chk("bp_no_retire", 32'(bus.retired), 32'(model_retired));
          @(negedge clk);
        end
        stall = 1'b0;
      end
    join

    // Reset while a MUL is in EXEC: it must vanish without a beat or a retire.
    regs[3] = 32'd11; regs[4] = 32'd13;
    @(negedge clk);
    waited = 0;
    while (!bus.instr_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    bus.instr_valid = 1'b1;
    bus.instr = mk_r(3, 4, 8, 6'h18);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("midrst_sel", 32'(bus.sel), 32'd7);
    chk("midrst_retired", 32'(bus.retired), 32'd0);
    chk("midrst_ready", 32'(bus.instr_ready), 32'd0);
    model_retired = '0;
    rst_n = 1'b1;
    regs[1] = 32'd5; regs[2] = 32'd9;
    send(32'h0022A020);

    for (int i = 0; i < 150; i++) begin
      randomize_regs();
      send(rand_instr());
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
